// File: rtl/prime_ctrl_pkg.sv
// Shared types and constants for the prime sieve/scan run controller.
// Holds the FSM state encoding (also exported on run_state for debug), the four
// scan modes selected by the keys, the active-low mode LED patterns and small
// helpers that decode a mode into scan direction and pacing speed.
package prime_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SIEVE  = 3'd2,
    ST_RUN    = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_FINISH = 3'd5
  } run_state_t;

  // Mode value equals the index of the key that selects it.
  typedef enum logic [1:0] {
    ASC_SLOW  = 2'd0,
    DESC_SLOW = 2'd1,
    ASC_FAST  = 2'd2,
    DESC_FAST = 2'd3
  } mode_t;

  localparam logic [3:0] LED_OFF = 4'b1111;
  localparam logic [3:0] LED_MODE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Bit 0 of the mode is the direction (0 = ascending).
  function automatic logic mode_is_asc(input mode_t m);
    return ~m[0];
  endfunction

  // Bit 1 of the mode is the pacing (1 = free-running step).
  function automatic logic mode_is_fast(input mode_t m);
    return m[1];
  endfunction

endpackage

// File: rtl/prime_run_ctrl_if.sv
// Signal bundle between the run controller and its environment.
// Inputs to the controller: key_pulse (active-low one-cycle key pulses),
// one_second (1 Hz strobe), sieve_done and range_end (core status levels).
// Outputs from the controller: solver_rstn (core reset, active low), select
// (1 = ascending), tick (step enable), led (active-low mode LEDs) and
// run_state (FSM state for debug).
// The slave modport is the controller side, master is the driving side.
interface prime_run_ctrl_if;
  logic [3:0] key_pulse;
  logic       one_second;
  logic       sieve_done;
  logic       range_end;
  logic       solver_rstn;
  logic       select;
  logic       tick;
  logic [3:0] led;
  logic [2:0] run_state;

  modport master (
    output key_pulse, one_second, sieve_done, range_end,
    input  solver_rstn, select, tick, led, run_state
  );

  modport slave (
    input  key_pulse, one_second, sieve_done, range_end,
    output solver_rstn, select, tick, led, run_state
  );
endinterface

// File: rtl/prime_run_ctrl_key_prio_enc.sv
// Combinational priority encoder for the four active-low key pulses.
// Ports: key_pulse (in, 4, active low), pressed (out, 1, any key down),
// key_idx (out, 2, index of the lowest pressed key; 0 when none).
module key_prio_enc (
  input  logic [3:0] key_pulse,
  output logic       pressed,
  output logic [1:0] key_idx
);

  // Lowest index wins when several keys arrive together.
  always_comb begin
    pressed = 1'b1;
    key_idx = 2'd0;
    casez (key_pulse)
      4'b???0: key_idx = 2'd0;
      4'b??01: key_idx = 2'd1;
      4'b?011: key_idx = 2'd2;
      4'b0111: key_idx = 2'd3;
      default: pressed = 1'b0;
    endcase
  end

endmodule

// File: rtl/prime_run_ctrl.sv
// Mode and run sequencer for the prime sieve/scan core.
// Turns key presses into one of four scan modes, restarts the core through
// solver_rstn for CLR_CYCLES cycles, waits for the sieve, then paces the scan
// via tick (1 Hz pulses or held high), with pause/resume and a blinking finish
// indication on the mode LEDs.
// Ports: clk (system clock), rstn_signal (async active-low reset),
// bus (prime_run_ctrl_if.slave, all key/status inputs and registered outputs).
// Parameters: CLR_CYCLES (core reset length, >= 2), CNT_W (clear counter
// width, 2**CNT_W > CLR_CYCLES).
module prime_run_ctrl
  import prime_ctrl_pkg::*;
#(
  parameter int CLR_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             rstn_signal,
  prime_run_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);

  run_state_t       state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             solver_rstn_q, solver_rstn_d;
  logic             select_q, select_d;
  logic             tick_q, tick_d;
  logic [3:0]       led_q, led_d;

  logic             key_pressed;
  logic [1:0]       key_idx;
  mode_t            key_mode;
  logic             same_key;

  key_prio_enc u_key_prio_enc (
    .key_pulse (bus.key_pulse),
    .pressed   (key_pressed),
    .key_idx   (key_idx)
  );

  assign key_mode = mode_t'(key_idx);
  assign same_key = (key_mode == mode_q);

  // State and output registers; reset parks the core in reset with LEDs off.
  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      state_q       <= ST_IDLE;
      mode_q        <= ASC_SLOW;
      clr_cnt_q     <= '0;
      solver_rstn_q <= 1'b0;
      select_q      <= 1'b1;
      tick_q        <= 1'b0;
      led_q         <= LED_OFF;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      clr_cnt_q     <= clr_cnt_d;
      solver_rstn_q <= solver_rstn_d;
      select_q      <= select_d;
      tick_q        <= tick_d;
      led_q         <= led_d;
    end
  end

  // Next-state logic. A key always outranks the status levels; the clear
  // counter only advances while CLEAR holds with no key, otherwise it is 0,
  // so any restart gets the full CLR_CYCLES of core reset.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    clr_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (key_pressed) begin
          state_d = ST_CLEAR;
          mode_d  = key_mode;
        end
      end
      ST_CLEAR: begin
        if (key_pressed) begin
          mode_d = key_mode;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_SIEVE;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      ST_SIEVE: begin
        if (key_pressed && !same_key) begin
          state_d = ST_CLEAR;
          mode_d  = key_mode;
        end else if (bus.sieve_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (key_pressed) begin
          if (same_key) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_CLEAR;
            mode_d  = key_mode;
          end
        end else if (bus.range_end) begin
          state_d = ST_FINISH;
        end
      end
      ST_PAUSE: begin
        if (key_pressed) begin
          state_d = same_key ? ST_RUN : ST_CLEAR;
          mode_d  = key_mode;
        end
      end
      ST_FINISH: begin
        if (key_pressed) begin
          state_d = ST_CLEAR;
          mode_d  = key_mode;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, computed from the next state so every output is a flop
  // that lines up with the state it belongs to. Slow tick is the one_second
  // strobe re-timed by one cycle and suppressed by a same-cycle key.
  always_comb begin
    solver_rstn_d = 1'b0;
    select_d      = 1'b1;
    tick_d        = 1'b0;
    led_d         = LED_OFF;
    if (state_d != ST_IDLE) begin
      select_d = mode_is_asc(mode_d);
      led_d    = LED_MODE[mode_d];
    end
    case (state_d)
      ST_SIEVE, ST_PAUSE: solver_rstn_d = 1'b1;
      ST_RUN: begin
        solver_rstn_d = 1'b1;
        tick_d        = mode_is_fast(mode_d) | (bus.one_second & ~key_pressed);
      end
      ST_FINISH: begin
        solver_rstn_d = 1'b1;
        // First cycle of FINISH shows the mode; each strobe then toggles.
        if (state_q == ST_FINISH) begin
          if (bus.one_second) begin
            led_d = (led_q == LED_OFF) ? LED_MODE[mode_q] : LED_OFF;
          end else begin
            led_d = led_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.solver_rstn = solver_rstn_q;
  assign bus.select      = select_q;
  assign bus.tick        = tick_q;
  assign bus.led         = led_q;
  assign bus.run_state   = state_q;

endmodule
